// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator (PRGA) that decrypts a ROM-held message into RAM.
// Walks the already-shuffled S array, XORs each keystream byte with one
// ciphertext byte, and optionally aborts on the first non-printable result.
module rc4_prga_decrypt #(
    parameter int unsigned MSG_LEN  = 32,
    parameter bit          CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rdata,
    output logic [7:0] s_wdata,
    output logic       s_wr_en,
    output logic [7:0] enc_addr,
    input  logic [7:0] enc_rdata,
    output logic [7:0] dec_addr,
    output logic [7:0] dec_wdata,
    output logic       dec_wr_en
);

    localparam int unsigned DW     = 8;
    localparam logic [DW-1:0] LAST_K = DW'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE,
        INC_I,
        RD_SI,
        WAIT1,
        LAT_SI,
        RD_SJ,
        WAIT2,
        LAT_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        WAIT3,
        LAT_F,
        WR_DEC,
        CHECK,
        FINISH
    } state_t;

    state_t        state;
    logic [DW-1:0] i;
    logic [DW-1:0] j;
    logic [DW-1:0] k;
    logic [DW-1:0] si;
    logic [DW-1:0] sj;
    logic [DW-1:0] f;
    logic [DW-1:0] enc_byte;

    // Accepted plaintext alphabet: space and lowercase letters.
    function automatic logic is_printable(input logic [DW-1:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    // Sequencer: one pass of INC_I..CHECK per message byte, registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            sj        <= '0;
            f         <= '0;
            enc_byte  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wr_en   <= 1'b0;
            enc_addr  <= '0;
            dec_addr  <= '0;
            dec_wdata <= '0;
            dec_wr_en <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        fail  <= 1'b0;
                        busy  <= 1'b1;
                        state <= INC_I;
                    end
                end
                INC_I: begin
                    i     <= i + DW'(1);
                    state <= RD_SI;
                end
                RD_SI: begin
                    s_addr <= i;
                    state  <= WAIT1;
                end
                WAIT1:  state <= LAT_SI;
                LAT_SI: begin
                    si    <= s_rdata;
                    j     <= j + s_rdata;
                    state <= RD_SJ;
                end
                RD_SJ: begin
                    s_addr <= j;
                    state  <= WAIT2;
                end
                WAIT2:  state <= LAT_SJ;
                LAT_SJ: begin
                    sj    <= s_rdata;
                    state <= WR_SI;
                end
                WR_SI: begin
                    s_addr  <= i;
                    s_wdata <= sj;
                    s_wr_en <= 1'b1;
                    state   <= WR_SJ;
                end
                WR_SJ: begin
                    s_addr  <= j;
                    s_wdata <= si;
                    s_wr_en <= 1'b1;
                    state   <= RD_F;
                end
                RD_F: begin
                    s_wr_en  <= 1'b0;
                    s_addr   <= si + sj;
                    enc_addr <= k;
                    state    <= WAIT3;
                end
                WAIT3:  state <= LAT_F;
                LAT_F: begin
                    f        <= s_rdata;
                    enc_byte <= enc_rdata;
                    state    <= WR_DEC;
                end
                WR_DEC: begin
                    dec_addr  <= k;
                    dec_wdata <= f ^ enc_byte;
                    dec_wr_en <= 1'b1;
                    state     <= CHECK;
                end
                CHECK: begin
                    dec_wr_en <= 1'b0;
                    if (CHECK_EN && !is_printable(dec_wdata)) begin
                        fail  <= 1'b1;
                        state <= FINISH;
                    end else if (k == LAST_K) begin
                        state <= FINISH;
                    end else begin
                        k     <= k + DW'(1);
                        state <= INC_I;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rc4_prga_decrypt.md
Name: rc4_prga_decrypt

Overview:
- Downstream neighbour of the key-schedule shuffle stage. Starts once the 256-byte S array has been shuffled.
- Runs the RC4 pseudo-random generation loop over S and XORs each keystream byte with one byte of the encrypted-message ROM.
- Writes each decrypted byte to the decrypted-message RAM.
- Optionally flags non-printable plaintext so the key-search controller can abort and try the next key.

Parameters:
- MSG_LEN, 32, number of message bytes processed (1..256).
- CHECK_EN, 1, 1 = abort on first byte outside {0x20, 0x61..0x7A}; 0 = never abort.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse; accepted only in IDLE.
- busy  output  1  high from the cycle after start until the cycle done is asserted.
- done  output  1  one-cycle pulse at completion or abort.
- fail  output  1  level; valid with done; cleared on next accepted start.
- s_addr  output  8  S RAM address.
- s_rdata  input  8  S RAM read data.
- s_wdata  output  8  S RAM write data.
- s_wr_en  output  1  S RAM write enable.
- enc_addr  output  8  encrypted ROM address.
- enc_rdata  input  8  encrypted ROM data.
- dec_addr  output  8  decrypted RAM address.
- dec_wdata  output  8  decrypted RAM write data.
- dec_wr_en  output  1  decrypted RAM write enable.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it takes effect at the clk edge where it is sampled high.
- Reset values: all outputs 0; state IDLE; i = j = k = 0; internal si, sj, f registers 0.
- Reset mid-operation: returns to IDLE on that edge, no further writes, no done pulse.
- Register rules: all outputs are registered; all addresses are driven from registers.
- Memory read timing: read data for an address driven in cycle N is sampled in cycle N+2, so every read state is followed by one WAIT state.
- Memory write timing: writes take effect at the edge ending the cycle in which wr_en is high.
- Arithmetic: i, j and S-index sums are 8-bit, wrapping mod 256. k counts 0..MSG_LEN-1.
- FSM sequence for each message byte k:
  - IDLE: on start, clear i, j, k and fail; go to INC_I.
  - INC_I: i <= i+1.
  - RD_SI: s_addr <= i. WAIT1.
  - LAT_SI: si <= s_rdata; j <= j + s_rdata.
  - RD_SJ: s_addr <= j. WAIT2.
  - LAT_SJ: sj <= s_rdata.
  - WR_SI: s_addr <= i, s_wdata <= sj, s_wr_en = 1.
  - WR_SJ: s_addr <= j, s_wdata <= si, s_wr_en = 1.
  - RD_F: s_addr <= si+sj; enc_addr <= k. WAIT3.
  - LAT_F: f <= s_rdata; capture enc_rdata.
  - WR_DEC: dec_addr <= k, dec_wdata <= f ^ enc byte, dec_wr_en = 1.
  - CHECK:
    - If CHECK_EN and dec byte is not in {0x20, 0x61..0x7A}: fail <= 1, go to FINISH.
    - Else if k == MSG_LEN-1: go to FINISH.
    - Else: k <= k+1, go to INC_I.
  - FINISH: done = 1 for one cycle; return to IDLE.
- Loop cost: 14 cycles per byte. Full success latency is 14*MSG_LEN + 2 cycles from start to done (448 + 2 = 450 for 32 bytes).
- Write-enable rules:
  - s_wr_en is only high in WR_SI and WR_SJ.
  - dec_wr_en is only high in WR_DEC.
  - At most one write enable is high in any cycle.
- i == j: both swap writes go to the same address with the same value; S is unchanged. This is legal and needs no special casing.
- start while busy: ignored. start coincident with reset: reset wins.
- S retention: S is left in its post-swap state; the shuffle stage re-initialises it before every key.
- On abort: bytes already written to decrypted RAM stay written; no further writes.

Test Plan:
- Identity S (S[x]=x), ROM = 0x63, 0x60, then zeros, CHECK_EN=0, MSG_LEN=2 -> byte 0: i=1, j=1, f=S[2]=0x02, dec[0]=0x61. Byte 1: i=2, j=3, S[2]=3, S[3]=2, f=S[5]=0x05, dec[1]=0x65. done at cycle 30 after start; fail=0.
- Same S, all-zero ROM, CHECK_EN=1 -> dec[0]=0x02 written; fail=1; done pulse; no write to dec_addr 1.
- Reset asserted during WR_SJ of byte 3 -> next cycle: IDLE, all outputs 0, no done. A later start from the re-initialised S reproduces the golden 32-byte plaintext exactly.
- Known-answer: S shuffled with key 0x000249, MSG_LEN=32, ROM = corresponding ciphertext -> 32 bytes match the software RC4 model; fail=0; done exactly 450 cycles after start.
- start pulsed again while busy, and start held for 3 cycles -> only one run; exactly one done pulse.
- Monitor throughout all tests -> s_wr_en and dec_wr_en are never high together; no write to dec_addr >= MSG_LEN.
